bus_line_fill: RTL

BUS_LINE_FILL -- requirements
Module: bus_line_fill

---
 rtl/bus_line_fill.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bus_line_fill.sv
// Instruction-cache line fill: assembles one LINE_W line from BEATS sequential memory beats.
// Define BUS_LINE_FILL_BUF_EN to add a last-line buffer that answers repeat requests without memory traffic.
module bus_line_fill #(
  parameter int unsigned LINE_W = 1024,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              b_rd,
  input  logic [63:0]       b_addr,
  output logic [LINE_W-1:0] b_data,
  output logic              b_dv,
  output logic              m_rd,
  output logic [63:0]       m_addr,
  input  logic [BEAT_W-1:0] m_data,
  input  logic              m_ack
);

  localparam int unsigned BEATS    = LINE_W / BEAT_W;
  localparam int unsigned CNT_W    = $clog2(BEATS);
  localparam int unsigned OFS_W    = $clog2(BEAT_W / 8);
  localparam int unsigned LINE_LSB = CNT_W + OFS_W;
  localparam int unsigned TAG_W    = 64 - LINE_LSB;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [TAG_W-1:0] line;
  logic [CNT_W-1:0] beat;
  logic [TAG_W-1:0] req_line;
  logic             abort;
  logic             hit;
  logic             latch;
  logic             beat_wr;
  logic             m_rd_d;
  logic             b_dv_d;
  logic             unused_ofs;

  assign req_line   = b_addr[63:LINE_LSB];
  assign abort      = !b_rd || (req_line != line);
  assign m_addr     = {line, beat, OFS_W'(0)};
  assign unused_ofs = ^b_addr[LINE_LSB-1:0];

`ifdef BUS_LINE_FILL_BUF_EN
  logic             buf_valid;
  logic [TAG_W-1:0] buf_tag;

  assign hit = buf_valid && (buf_tag == req_line);

  // Valid drops as soon as a fetch starts overwriting b_data; re-armed when a line completes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else if (state == IDLE && next_state == FETCH) begin
      buf_valid <= 1'b0;
    end else if (state == DONE) begin
      buf_valid <= 1'b1;
      buf_tag   <= line;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      m_rd  <= 1'b0;
      b_dv  <= 1'b0;
    end else begin
      state <= next_state;
      m_rd  <= m_rd_d;
      b_dv  <= b_dv_d;
    end
  end

  // Abort takes priority over completion so a stale line is never reported.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (b_rd) next_state = hit ? DONE : FETCH;
      end
      FETCH: begin
        if (abort)                                next_state = m_ack ? IDLE : DRAIN;
        else if (m_ack && (beat == LAST_BEAT))    next_state = DONE;
      end
      DRAIN: begin
        if (m_ack) next_state = IDLE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    latch   = 1'b0;
    beat_wr = 1'b0;
    m_rd_d  = (next_state == FETCH) || (next_state == DRAIN);
    b_dv_d  = (next_state == DONE);
    case (state)
      IDLE:    latch   = b_rd;
      FETCH:   beat_wr = m_ack;
      default: ;
    endcase
  end

  // Beat pointer only advances on a non-aborted ack, so DRAIN keeps the outstanding address.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      line   <= '0;
      beat   <= '0;
      b_data <= '0;
    end else begin
      if (latch) begin
        line <= req_line;
        beat <= '0;
      end else if (beat_wr && !abort && (beat != LAST_BEAT)) begin
        beat <= beat + CNT_W'(1);
      end
      if (beat_wr) b_data[beat * BEAT_W +: BEAT_W] <= m_data;
    end
  end

endmodule
